// File: rtl/fu_arb_pkg.sv
// Shared constants for the function-unit arbiter: FSM encoding, NOP select,
// flag bit positions and requester ids.
package fu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [4:0] FS_NOP = 5'b00000;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic n, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/fu_arbiter_seq_if.sv
// Request, function-unit and response signals of fu_arbiter_seq.
// slave = the arbiter itself, master = requesters/function unit/consumer.
interface fu_arbiter_seq_if #(
  parameter int DW  = 10,
  parameter int FSW = 5,
  parameter int SHW = 5
);
  logic           req0_valid;
  logic           req0_ready;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic [FSW-1:0] req0_fs;
  logic [SHW-1:0] req0_sh;

  logic           req1_valid;
  logic           req1_ready;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic [FSW-1:0] req1_fs;
  logic [SHW-1:0] req1_sh;

  logic [DW-1:0]  fu_a;
  logic [DW-1:0]  fu_b;
  logic [FSW-1:0] fu_fs;
  logic [SHW-1:0] fu_sh;
  logic [DW-1:0]  fu_f;
  logic           fu_z;
  logic           fu_c;
  logic           fu_n;
  logic           fu_v;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [DW-1:0]  rsp_f;
  logic [3:0]     rsp_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fs, req0_sh,
    input  req1_valid, req1_a, req1_b, req1_fs, req1_sh,
    output req0_ready, req1_ready,
    output fu_a, fu_b, fu_fs, fu_sh,
    input  fu_f, fu_z, fu_c, fu_n, fu_v,
    output rsp_valid, rsp_id, rsp_f, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_fs, req0_sh,
    output req1_valid, req1_a, req1_b, req1_fs, req1_sh,
    input  req0_ready, req1_ready,
    input  fu_a, fu_b, fu_fs, fu_sh,
    output fu_f, fu_z, fu_c, fu_n, fu_v,
    input  rsp_valid, rsp_id, rsp_f, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/fu_rr_arb2.sv
// Two-input grant selection. Round-robin on ties by default;
// FU_ARB_FIXED_PRIORITY_EN makes requester 0 always win a tie.
module fu_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant
);
  import fu_arb_pkg::*;

`ifdef FU_ARB_FIXED_PRIORITY_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst, accept};

  always_comb begin
    grant = valid0 ? REQ0_ID : (valid1 ? REQ1_ID : REQ0_ID);
  end
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = REQ0_ID;
    if (valid0 && valid1) grant = ~last_grant_q;
    else if (valid1)      grant = REQ1_ID;
  end

  // Reset to requester 1 so requester 0 takes the first tie.
  always_comb begin
    last_grant_d = last_grant_q;
    if (rst)         last_grant_d = REQ1_ID;
    else if (accept) last_grant_d = grant;
  end

  always_ff @(posedge clk) begin
    last_grant_q <= last_grant_d;
  end
`endif

endmodule

// File: rtl/fu_arbiter_seq.sv
// Shares one function unit between two requesters: arbitrate, register the
// operands, capture result/flags one cycle later, hold a tagged response.
module fu_arbiter_seq #(
  parameter int DW  = 10,
  parameter int FSW = 5,
  parameter int SHW = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  fu_arbiter_seq_if.slave bus
);
  import fu_arb_pkg::*;

  state_e         state_q, state_d;
  logic [DW-1:0]  fu_a_q, fu_a_d;
  logic [DW-1:0]  fu_b_q, fu_b_d;
  logic [FSW-1:0] fu_fs_q, fu_fs_d;
  logic [SHW-1:0] fu_sh_q, fu_sh_d;
  logic           id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [DW-1:0]  rsp_f_q, rsp_f_d;
  logic [3:0]     rsp_flags_q, rsp_flags_d;

  logic grant;
  logic accept;

  // Ready is only offered in IDLE and never while reset is asserted.
  assign accept = (state_q == ST_IDLE) && !RESET && (bus.req0_valid || bus.req1_valid);

  fu_rr_arb2 u_arb (
    .clk    (CLK),
    .rst    (RESET),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign bus.req0_ready = accept && (grant == REQ0_ID);
  assign bus.req1_ready = accept && (grant == REQ1_ID);

  always_comb begin
    state_d     = state_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    fu_fs_d     = fu_fs_q;
    fu_sh_d     = fu_sh_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_f_d     = rsp_f_q;
    rsp_flags_d = rsp_flags_q;
    if (RESET) begin
      state_d     = ST_IDLE;
      fu_a_d      = '0;
      fu_b_d      = '0;
      fu_fs_d     = FSW'(FS_NOP);
      fu_sh_d     = '0;
      id_d        = REQ0_ID;
      rsp_valid_d = 1'b0;
      rsp_id_d    = 1'b0;
      rsp_f_d     = '0;
      rsp_flags_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_EXEC;
            id_d    = grant;
            if (grant == REQ1_ID) begin
              fu_a_d  = bus.req1_a;
              fu_b_d  = bus.req1_b;
              fu_fs_d = bus.req1_fs;
              fu_sh_d = bus.req1_sh;
            end else begin
              fu_a_d  = bus.req0_a;
              fu_b_d  = bus.req0_b;
              fu_fs_d = bus.req0_fs;
              fu_sh_d = bus.req0_sh;
            end
          end
        end
        ST_EXEC: begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_f_d     = bus.fu_f;
          rsp_flags_d = pack_flags(bus.fu_z, bus.fu_c, bus.fu_n, bus.fu_v);
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    state_q     <= state_d;
    fu_a_q      <= fu_a_d;
    fu_b_q      <= fu_b_d;
    fu_fs_q     <= fu_fs_d;
    fu_sh_q     <= fu_sh_d;
    id_q        <= id_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_id_q    <= rsp_id_d;
    rsp_f_q     <= rsp_f_d;
    rsp_flags_q <= rsp_flags_d;
  end

  assign bus.fu_a      = fu_a_q;
  assign bus.fu_b      = fu_b_q;
  assign bus.fu_fs     = fu_fs_q;
  assign bus.fu_sh     = fu_sh_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_f     = rsp_f_q;
  assign bus.rsp_flags = rsp_flags_q;

endmodule

// File: doc/fu_arbiter_seq.md
Name: fu_arbiter_seq

Overview:
- Shares the single 10-bit function unit (ALU/shifter, FS/SH controlled, Z/C/N/V flags) between two requesters: req0 is the register-file datapath and req1 is the auxiliary/address path.
- Performs the valid/ready handshake, round-robin arbitration and operand registering, captures F and flags, and returns a tagged response.
- Sits between the control unit and the function unit. One operation is in flight at a time.

Parameters:
- DW, 10, operand/result width (must match function unit)
- FSW, 5, function-select width
- SHW, 5, shift-amount width

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  DW  operands
- req0_fs  in  FSW  function select
- req0_sh  in  SHW  shift amount
- req1_valid, req1_ready, req1_a, req1_b, req1_fs, req1_sh: same widths/meaning for requester 1
- fu_a, fu_b  out  DW  registered operands to function unit
- fu_fs  out  FSW  registered function select
- fu_sh  out  SHW  registered shift amount
- fu_f  in  DW  function unit result (combinational from fu_*)
- fu_z, fu_c, fu_n, fu_v  in  1  function unit flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  0 = requester 0, 1 = requester 1
- rsp_f  out  DW  captured result
- rsp_flags  out  4  {Z,C,N,V} captured

Behaviour:
- States: IDLE, EXEC, RESP. Encoding is a package constant.
- IDLE:
  - req*_ready is combinational: high only in IDLE, and only toward the granted requester whose valid is high.
  - On a handshake: latch that requester's a/b/fs/sh into fu_*, latch grant id, go to EXEC.
  - With no valid, stay in IDLE.
- Arbitration is round-robin via a last_grant bit:
  - If both are valid, grant the requester other than last_grant.
  - If one is valid, grant it regardless of last_grant.
  - last_grant updates only on a handshake.
- EXEC (exactly 1 cycle): fu_* are stable. At the clock edge, register fu_f into rsp_f, {fu_z,fu_c,fu_n,fu_v} into rsp_flags, and the id into rsp_id. Set rsp_valid and go to RESP.
- RESP:
  - rsp_valid stays high and rsp_* stay stable until rsp_ready is high.
  - The cycle with rsp_valid & rsp_ready completes the transfer. rsp_valid is low next cycle and the state returns to IDLE.
  - No new request is accepted in the completion cycle.
- Latency and throughput:
  - Handshake in cycle n gives rsp_valid in cycle n+2.
  - Minimum issue interval is 3 cycles (with rsp_ready held high).
- fu_* hold their last values between operations; they are never updated outside an IDLE handshake.
- A requester may drop valid without a handshake; nothing is consumed.
- Operand, result and flag values pass through unmodified. The block does no arithmetic on data.
- RESET (synchronous) wins over everything, including mid-EXEC or mid-RESP:
  - The in-flight op is discarded; no response is produced.
  - Reset state: IDLE, last_grant=1 (requester 0 wins the first tie).
  - Output reset values: rsp_valid=0, rsp_id=0, rsp_f=0, rsp_flags=0, fu_a=0, fu_b=0, fu_sh=0, fu_fs=FS_NOP.
  - Both ready outputs are 0 during the RESET cycle.

Optional Feature:
- Macro: FU_ARB_FIXED_PRIORITY_EN.
- Defined: requester 0 always wins when both are valid. last_grant is removed.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package fu_arb_pkg holds:
  - the state encoding (IDLE/EXEC/RESP)
  - FS_NOP = 5'b00000
  - flag bit indices (Z=3, C=2, N=1, V=0)
  - requester id constants
- Sub-module fu_rr_arb2 is natural: 2-input round-robin/fixed-priority grant with last_grant register. It contains the optional-feature logic.
- The FSM, operand registers and response registers stay in the top.

Test Plan:
- Reset then req0 only (a=10'h00F, b=10'h001, fs=5'b00010): req0_ready high cycle 0, fu_a=10'h00F cycle 1, rsp_valid cycle 2. Stub FU returns 10'h010, flags 4'b0000 → rsp_f=10'h010, rsp_id=0.
- Both valid every cycle, rsp_ready=1, round-robin build: grants alternate 0,1,0,1 starting with 0; one grant every 3 cycles.
- Same stimulus with FU_ARB_FIXED_PRIORITY_EN: every grant goes to 0; req1_ready never high.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_f and rsp_flags unchanged; both ready outputs stay 0; release gives one transfer, then IDLE.
- Flags capture: stub FU returns 10'h000 with Z=1, C=1 → rsp_flags=4'b1100.
- RESET asserted during EXEC → next cycle IDLE, rsp_valid=0, fu_fs=FS_NOP; a subsequent tie grants req0.
